ram_sc_reader: RTL and testbench
================================

Name: ram_sc_reader

Overview:
- Read-side engine for the single-clock byte-enabled block RAM (1-cycle registered read).
- On a start pulse, reads a run of consecutive rows from a base address and presents them, one per cycle, on a valid/ready stream with full back-pressure support.
- Sits between the RAM read port and a downstream consumer, such as the PCIe TX packetiser.
- Internal 3-entry buffer absorbs the RAM read latency, so throughput is 1 row/cycle with no combinational path from rdReady_in to ramAddr_out.

Parameters:
- ADDR_NBITS, 5, RAM row-address width; RAM depth = 2**ADDR_NBITS.
- NUM_SPANS, 8, spans per row.
- SPAN_NBITS, 8, bits per span; row width = NUM_SPANS*SPAN_NBITS.

Ports:
- clk_in  input  1  sole clock.
- reset_in  input  1  synchronous, active-high reset.
- start_in  input  1  1-cycle request pulse; sampled only in IDLE.
- baseAddr_in  input  ADDR_NBITS  first row address; sampled with start_in.
- count_in  input  ADDR_NBITS+1  rows to read (0..2**ADDR_NBITS); sampled with start_in.
- busy_out  output  1  high from the cycle after an accepted start until done_out.
- done_out  output  1  1-cycle pulse when the last row is accepted downstream.
- ramAddr_out  output  ADDR_NBITS  to RAM readAddr_in.
- ramData_in  input  NUM_SPANS*SPAN_NBITS  from RAM readData_out; valid 1 cycle after address.
- rdData_out  output  NUM_SPANS*SPAN_NBITS  stream data (head of buffer).
- rdValid_out  output  1  stream valid.
- rdReady_in  input  1  stream ready; transfer when valid and ready are both high on a clock edge.

Behaviour:
- Reset (sync, high):
  - state=IDLE; busy_out=0, done_out=0, rdValid_out=0, ramAddr_out=0.
  - Buffer emptied; in-flight flag and counters cleared.
  - rdData_out is don't-care.
- Reset mid-run: the run is abandoned. Buffered and in-flight rows are dropped, no done_out is produced, and the block is back in IDLE on the next cycle.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - start_in=1 with count_in>0 → RUN. Load addr=baseAddr_in, issueRemain=count_in, acceptRemain=count_in.
  - start_in=1 with count_in=0 → done_out pulses the next cycle; no rows; stay IDLE.
- RUN:
  - Issue condition (evaluated each cycle): issueRemain>0 and (occupancy + inflight) < 3.
  - On issue: ramAddr_out=addr this cycle; inflight=1 next cycle; addr increments; issueRemain decrements.
  - addr wraps modulo 2**ADDR_NBITS (e.g. 31→0 when ADDR_NBITS=5).
  - When the last read is issued → DRAIN.
- Capture: in the cycle after an issue, ramData_in is pushed into the buffer tail. Push and pop may occur in the same cycle; occupancy is then unchanged.
- Output:
  - rdValid_out = (occupancy>0).
  - rdData_out = head entry, stable while valid and not ready.
  - Each transfer decrements acceptRemain.
- DRAIN: when the final transfer occurs (acceptRemain 1→0), done_out pulses in the next cycle and state → IDLE in the same cycle. busy_out is low in that cycle.
- start_in while busy_out=1 is ignored: no queueing, no effect on the current run.
- Latency: start_in sampled at edge of cycle 0 → first ramAddr_out issue in cycle 1 → rdValid_out first high in cycle 3.
- Throughput: with rdReady_in held high, one row per cycle. A run of N rows completes its last transfer in cycle N+2; done_out pulses in cycle N+3.
- Back-pressure: reads stall when 3 rows are buffered or in flight, so no row is ever lost or duplicated.
- ramAddr_out holds its last value when not issuing (the RAM reads continuously; harmless).
- Ordering: rows are emitted strictly in address order.

Decomposition:
- Shared package ram_pkg:
  - typedef Data (SPAN_NBITS bits).
  - typedef Row (NUM_SPANS x Data), shared with ram_sc_be users.
  - localparam RD_BUF_DEPTH=3.
  - State enum {IDLE, RUN, DRAIN}.
- Sub-module ram_rd_fifo: 3-entry, Row-wide, synchronous FIFO.
  - Inputs: push, pop, data.
  - Outputs: occupancy (2 bits), head.
  - Push+pop in the same cycle is legal; push when full and pop when empty are assertion errors.
- Top-level contents: FSM, address/issue/accept counters, in-flight flag.

Test Plan:
- Streaming: RAM preloaded row[i]=i replicated in every span; base=0, count=4, rdReady_in=1 → rows 0,1,2,3 on cycles 3..6; done_out pulses in cycle 7; busy_out high cycles 1..6.
- Wrap: ADDR_NBITS=5, base=30, count=4 → ramAddr_out sequence 30,31,0,1; data in that order.
- Back-pressure: count=8; rdReady_in toggles 1,0,0,1,… (random) → all 8 rows emitted exactly once, in order; (occupancy + inflight) never exceeds 3; rdData_out stable while stalled.
- Edge counts: count=0 → done_out the next cycle, rdValid_out never high. count=32 (full RAM) → all 32 rows emitted, base row not repeated.
- Start while busy: start_in pulsed mid-run with different base/count → ignored; original run completes unchanged; a start in the cycle after done_out is accepted.
- Reset mid-run: count=8, reset_in asserted after 3 transfers → next cycle busy_out=0, rdValid_out=0, no done_out; a fresh run then behaves as in the streaming scenario.

Source files
------------

// File: rtl/ram_pkg.sv
`default_nettype none
// ============================================================================
// ram_pkg
// Shared row/span types and read-buffer constants for the block RAM and its
// read-side engine.
// Revision: 1.0
// ============================================================================
package ram_pkg;

  localparam int SPAN_NBITS_DEF = 8;
  localparam int NUM_SPANS_DEF  = 8;
  localparam int RD_BUF_DEPTH   = 3;

  typedef logic [SPAN_NBITS_DEF-1:0] Data;
  typedef Data  [NUM_SPANS_DEF-1:0]  Row;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } State;

endpackage
`default_nettype wire

// File: rtl/ram_rd_fifo.sv
`default_nettype none
// ============================================================================
// ram_rd_fifo
// Small synchronous FIFO (up to 3 entries) buffering RAM rows for the reader.
// Revision: 1.0
// ============================================================================
module ram_rd_fifo
  import ram_pkg::*;
#(
  parameter int WIDTH = NUM_SPANS_DEF * SPAN_NBITS_DEF,
  parameter int DEPTH = RD_BUF_DEPTH
) (
  input  logic             clk_in,
  input  logic             reset_in,
  input  logic             push_in,
  input  logic             pop_in,
  input  logic [WIDTH-1:0] data_in,
  output logic [1:0]       occupancy_out,
  output logic [WIDTH-1:0] head_out
);

  localparam logic [1:0] c_ptr_last = 2'(DEPTH - 1);
  localparam logic [1:0] c_full     = 2'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [1:0]       r_wr_ptr;
  logic [1:0]       r_rd_ptr;
  logic [1:0]       r_count;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == c_ptr_last) ? 2'd0 : p + 2'd1;
  endfunction

  always_ff @(posedge clk_in) begin
    if (push_in) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_wr_ptr <= 2'd0;
      r_rd_ptr <= 2'd0;
      r_count  <= 2'd0;
    end else begin
      if (push_in) r_wr_ptr <= next_ptr(r_wr_ptr);
      if (pop_in)  r_rd_ptr <= next_ptr(r_rd_ptr);
      case ({push_in, pop_in})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign occupancy_out = r_count;
  assign head_out      = r_mem[r_rd_ptr];

  a_no_overflow : assert property (@(posedge clk_in) disable iff (reset_in)
    !(push_in && !pop_in && (r_count == c_full)));
  a_no_underflow : assert property (@(posedge clk_in) disable iff (reset_in)
    !(pop_in && (r_count == 2'd0)));

endmodule
`default_nettype wire

// File: rtl/ram_sc_reader.sv
`default_nettype none
// ============================================================================
// ram_sc_reader
// Streams a run of consecutive RAM rows onto a valid/ready interface.
// Revision: 1.0
// ============================================================================
module ram_sc_reader
  import ram_pkg::*;
#(
  parameter int ADDR_NBITS = 5,
  parameter int NUM_SPANS  = NUM_SPANS_DEF,
  parameter int SPAN_NBITS = SPAN_NBITS_DEF
) (
  input  logic                            clk_in,
  input  logic                            reset_in,
  input  logic                            start_in,
  input  logic [ADDR_NBITS-1:0]           baseAddr_in,
  input  logic [ADDR_NBITS:0]             count_in,
  output logic                            busy_out,
  output logic                            done_out,
  output logic [ADDR_NBITS-1:0]           ramAddr_out,
  input  logic [NUM_SPANS*SPAN_NBITS-1:0] ramData_in,
  output logic [NUM_SPANS*SPAN_NBITS-1:0] rdData_out,
  output logic                            rdValid_out,
  input  logic                            rdReady_in
);

  localparam int ROW_NBITS = NUM_SPANS * SPAN_NBITS;
  localparam int CNT_NBITS = ADDR_NBITS + 1;
  localparam logic [CNT_NBITS-1:0] c_one   = CNT_NBITS'(1);
  localparam logic [2:0]           c_depth = 3'(RD_BUF_DEPTH);

  State                  r_state;
  logic [ADDR_NBITS-1:0] r_addr;
  logic [ADDR_NBITS-1:0] r_addr_hold;
  logic [CNT_NBITS-1:0]  r_issue_remain;
  logic [CNT_NBITS-1:0]  r_accept_remain;
  logic                  r_inflight;
  logic                  r_busy;
  logic                  r_done;

  logic [1:0]            w_occupancy;
  logic                  w_issue;
  logic                  w_pop;

  // Issue decision uses only registered state, keeping rdReady_in off the address path.
  assign w_issue = (r_state == RUN) && (r_issue_remain != '0) &&
                   (({1'b0, w_occupancy} + {2'b00, r_inflight}) < c_depth);
  assign w_pop   = rdValid_out && rdReady_in;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_state         <= IDLE;
      r_addr          <= '0;
      r_addr_hold     <= '0;
      r_issue_remain  <= '0;
      r_accept_remain <= '0;
      r_inflight      <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_done     <= 1'b0;
      r_inflight <= w_issue;
      if (w_issue) begin
        r_addr         <= r_addr + 1'b1;
        r_addr_hold    <= r_addr;
        r_issue_remain <= r_issue_remain - 1'b1;
      end
      if (w_pop) begin
        r_accept_remain <= r_accept_remain - 1'b1;
      end
      case (r_state)
        IDLE: begin
          if (start_in) begin
            if (count_in != '0) begin
              r_state         <= RUN;
              r_busy          <= 1'b1;
              r_addr          <= baseAddr_in;
              r_issue_remain  <= count_in;
              r_accept_remain <= count_in;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        RUN: begin
          if (w_issue && (r_issue_remain == c_one)) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_pop && (r_accept_remain == c_one)) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  ram_rd_fifo #(
    .WIDTH (ROW_NBITS),
    .DEPTH (RD_BUF_DEPTH)
  ) u_fifo (
    .clk_in        (clk_in),
    .reset_in      (reset_in),
    .push_in       (r_inflight),
    .pop_in        (w_pop),
    .data_in       (ramData_in),
    .occupancy_out (w_occupancy),
    .head_out      (rdData_out)
  );

  assign ramAddr_out = w_issue ? r_addr : r_addr_hold;
  assign rdValid_out = (w_occupancy != 2'd0);
  assign busy_out    = r_busy;
  assign done_out    = r_done;

endmodule
`default_nettype wire

// File: tb/tb_ram_sc_reader.sv
`default_nettype none
// ============================================================================
// tb_ram_sc_reader
// Directed testbench for ram_sc_reader with a registered-read RAM model.
// Revision: 1.0
// ============================================================================
module tb_ram_sc_reader;
  import ram_pkg::*;

  logic        clk_in = 1'b0;
  logic        reset_in;
  logic        start_in;
  logic [4:0]  base_addr;
  logic [5:0]  count;
  logic        busy;
  logic        done;
  logic [4:0]  ram_addr;
  logic [63:0] ram_data;
  logic [63:0] rd_data;
  logic        rd_valid;
  logic        rd_ready;

  logic [63:0] mem [32];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) ram_data <= mem[ram_addr];

  ram_sc_reader #(
    .ADDR_NBITS (5),
    .NUM_SPANS  (8),
    .SPAN_NBITS (8)
  ) dut (
    .clk_in      (clk_in),
    .reset_in    (reset_in),
    .start_in    (start_in),
    .baseAddr_in (base_addr),
    .count_in    (count),
    .busy_out    (busy),
    .done_out    (done),
    .ramAddr_out (ram_addr),
    .ramData_in  (ram_data),
    .rdData_out  (rd_data),
    .rdValid_out (rd_valid),
    .rdReady_in  (rd_ready)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic Row row_of(input int a);
    Row r;
    for (int s = 0; s < NUM_SPANS_DEF; s++) r[s] = Data'(a % 32);
    return r;
  endfunction

  // Starts a run and follows it to done_out. Without back-pressure the full
  // cycle-accurate timeline is checked; poke fires an ignored start mid-run.
  task automatic run_check(input int base, input int cnt, input bit bp, input bit poke);
    int          cyc;
    int          k;
    int          bp_idx;
    int          done_cyc;
    bit          got_done;
    bit          prev_stall;
    logic [63:0] prev_data;
    cyc = 1; k = 0; bp_idx = 0; got_done = 1'b0; prev_stall = 1'b0; prev_data = '0;
    done_cyc = (cnt == 0) ? 1 : cnt + 3;
    @(negedge clk_in);
    start_in = 1'b1; base_addr = 5'(base); count = 6'(cnt); rd_ready = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    while (!got_done && cyc < 400) begin
      if (bp) begin
        if (bp_idx < 4) rd_ready = (bp_idx == 0 || bp_idx == 3);
        else            rd_ready = 1'($urandom_range(0, 1));
        bp_idx++;
      end else begin
        rd_ready = 1'b1;
        if (cyc <= cnt) check_eq("ram_addr", 64'(ram_addr), 64'((base + cyc - 1) % 32));
        check_eq("busy", 64'(busy), 64'(cnt > 0 && cyc <= cnt + 2));
        check_eq("valid", 64'(rd_valid), 64'(cnt > 0 && cyc >= 3 && cyc <= cnt + 2));
        check_eq("done", 64'(done), 64'(cyc == done_cyc));
      end
      if (prev_stall) begin
        check_eq("stall_valid", 64'(rd_valid), 64'd1);
        check_eq("stall_data", rd_data, prev_data);
      end
      check_eq("outstanding_le_3",
               64'((int'(dut.w_occupancy) + int'(dut.r_inflight)) <= 3), 64'd1);
      if (done) begin
        got_done = 1'b1;
        check_eq("done_rows", 64'(k), 64'(cnt));
        check_eq("done_busy", 64'(busy), 64'd0);
      end
      if (rd_valid && rd_ready) begin
        check_eq("row_data", rd_data, row_of(base + k));
        k++;
      end
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data;
      start_in   = poke && (cyc == 4);
      if (start_in) begin
        base_addr = 5'd7; count = 6'd2;
      end
      if (!got_done) begin
        @(negedge clk_in);
        cyc++;
      end
    end
    start_in = 1'b0;
    if (!got_done) check_eq("done_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = row_of(i);
    reset_in = 1'b1; start_in = 1'b0; base_addr = '0; count = '0; rd_ready = 1'b1;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    check_eq("rst_valid", 64'(rd_valid), 64'd0);
    check_eq("rst_addr", 64'(ram_addr), 64'd0);
    reset_in = 1'b0;

    run_check(0, 4, 1'b0, 1'b0);    // streaming
    run_check(30, 4, 1'b0, 1'b0);   // address wrap 30,31,0,1
    run_check(0, 8, 1'b1, 1'b0);    // back-pressure
    run_check(21, 8, 1'b1, 1'b0);   // back-pressure across wrap
    run_check(0, 0, 1'b0, 1'b0);    // empty run
    run_check(9, 32, 1'b0, 1'b0);   // whole RAM
    run_check(3, 6, 1'b0, 1'b1);    // start while busy ignored
    run_check(12, 3, 1'b0, 1'b0);   // start right after done

    // Reset in the middle of an 8-row run after three transfers.
    @(negedge clk_in);
    start_in = 1'b1; base_addr = 5'd0; count = 6'd8; rd_ready = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    repeat (5) @(negedge clk_in);
    check_eq("mid_head", rd_data, row_of(3));
    reset_in = 1'b1;
    @(negedge clk_in);
    reset_in = 1'b0;
    check_eq("mid_rst_busy", 64'(busy), 64'd0);
    check_eq("mid_rst_valid", 64'(rd_valid), 64'd0);
    check_eq("mid_rst_done", 64'(done), 64'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_in);
      check_eq("post_rst_done", 64'(done), 64'd0);
      check_eq("post_rst_valid", 64'(rd_valid), 64'd0);
    end
    run_check(0, 4, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
